// File: rtl/wb_scheduler.sv
// Writeback scheduler: round-robin arbitration of execution-unit results onto the single
// register-file write port, plus a pending-write scoreboard for decode hazard detection.
module wb_scheduler #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        iss_valid_i,
    input  logic                        iss_wr_i,
    input  logic [ADDR_W-1:0]           iss_rd_i,
    input  logic [ADDR_W-1:0]           iss_rs1_i,
    input  logic [ADDR_W-1:0]           iss_rs2_i,
    output logic                        hazard_o,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic                        w_en_o,
    output logic [ADDR_W-1:0]           w_addr_o,
    output logic [DATA_W-1:0]           w_data_o,
    output logic [REG_NUM-1:0]          pending_o
);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [REG_NUM-1:0] pending_q, pending_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               w_en_q;
    logic [ADDR_W-1:0]  w_addr_q;
    logic [DATA_W-1:0]  w_data_q;

    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W:0]     cand;
    logic               found;
    logic               xfer;
    logic               wr_fire;
    logic               issue_set;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    // Search from rr_ptr upward with wrap-around; first valid requester wins.
    always_comb begin
        grant   = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!found && req_valid_i[cand[PTR_W-1:0]]) begin
                found                    = 1'b1;
                win_idx                  = cand[PTR_W-1:0];
                grant[cand[PTR_W-1:0]]   = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr_i[i*ADDR_W +: ADDR_W];
                sel_data = req_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign xfer    = |grant;
    assign wr_fire = xfer && (sel_addr != '0);

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            rr_ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    assign hazard_o = iss_valid_i & (pending_q[iss_rs1_i] | pending_q[iss_rs2_i] |
                                     (iss_wr_i & pending_q[iss_rd_i]));
    assign issue_set = iss_valid_i & ~hazard_o & iss_wr_i & (iss_rd_i != '0);

    // Clear before set so a same-edge set on the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (wr_fire) begin
            pending_d[sel_addr] = 1'b0;
        end
        if (issue_set) begin
            pending_d[iss_rd_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            rr_ptr_q  <= '0;
            w_en_q    <= 1'b0;
            w_addr_q  <= '0;
            w_data_q  <= '0;
        end else begin
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
            w_en_q    <= wr_fire;
            // Zeroed when idle: the register file bypasses w_data on address match alone.
            w_addr_q  <= wr_fire ? sel_addr : '0;
            w_data_q  <= wr_fire ? sel_data : '0;
        end
    end

    assign req_ready_o = grant;
    assign w_en_o      = w_en_q;
    assign w_addr_o    = w_addr_q;
    assign w_data_o    = w_data_q;
    assign pending_o   = pending_q;

endmodule

// File: doc/wb_scheduler.md
# wb_scheduler

Writeback scheduler and register scoreboard for the register file's single write port. Execution units (ALU, LSU, MDU, ...) post results through valid/ready handshakes; the block grants one request per cycle round-robin and drives the register-file write port from a registered stage. It also tracks which architectural registers have a write outstanding, so decode can stall on RAW/WAW hazards. It sits between the execute units and the register file, alongside decode.

## Interface
- NUM_REQ, 3, number of writeback requesters (2..8)
- REG_NUM, 32, number of architectural registers (x0 hardwired zero)
- ADDR_W, 5, register address width
- DATA_W, 32, register data width

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- iss_valid_i  in  1  decode presents an instruction this cycle
- iss_wr_i  in  1  instruction writes rd
- iss_rd_i  in  ADDR_W  destination register
- iss_rs1_i  in  ADDR_W  source register 1
- iss_rs2_i  in  ADDR_W  source register 2
- hazard_o  out  1  issue blocked (combinational)
- req_valid_i  in  NUM_REQ  per-unit writeback request
- req_addr_i  in  NUM_REQ*ADDR_W  per-unit rd, unit i at bits [i*ADDR_W +: ADDR_W]
- req_data_i  in  NUM_REQ*DATA_W  per-unit result, same packing
- req_ready_o  out  NUM_REQ  one-hot grant (combinational)
- w_en_o  out  1  register-file write enable (registered)
- w_addr_o  out  ADDR_W  register-file write address (registered)
- w_data_o  out  DATA_W  register-file write data (registered)
- pending_o  out  REG_NUM  scoreboard bits, for debug and verification

## Operation
- Scoreboard: pending[REG_NUM-1:0]; pending[0] is constant 0.
- hazard_o = iss_valid_i & (pending[rs1] | pending[rs2] | (iss_wr_i & pending[rd])).
- An issue is accepted when iss_valid_i & ~hazard_o. If iss_wr_i is high and rd != 0, pending[rd] is set at the next edge.
- Arbitration uses a round-robin pointer rr_ptr, 0..NUM_REQ-1.
  - The winner is the first requester with req_valid_i high, searching rr_ptr, rr_ptr+1, ... with wrap-around.
  - req_ready_o is one-hot for the winner, or all zero when no request is valid.
  - A transfer occurs when req_valid_i[i] & req_ready_o[i].
  - On a transfer, rr_ptr becomes winner+1, wrapping at NUM_REQ to 0. With no transfer, rr_ptr holds.
- Output stage, loaded every cycle:
  - Transfer with addr != 0: w_en_o=1, w_addr_o=addr, w_data_o=data.
  - No transfer, or a transfer with addr == 0: w_en_o=0, w_addr_o=0, w_data_o=0. Zeroing is mandatory because the register file bypasses w_data onto any read whose address matches w_addr regardless of w_en.
  - A transfer to x0 is still accepted (ready high) and consumed, but nothing is written.
- A transfer with addr != 0 clears pending[addr] at the same edge that loads the output stage.
- Same-edge set and clear of one register: set wins. This case is only reachable by a protocol violation; the bench flags it.
- A transfer to a non-pending register is written normally; the scoreboard is unchanged.
- Requesters must hold valid, addr and data stable until ready is seen. The block never drops a valid request; a lower-priority unit waits at most NUM_REQ-1 cycles.

## Timing
- Reset (async assert, sync deassert externally) sets:
  - pending=0, rr_ptr=0
  - w_en_o=0, w_addr_o=0, w_data_o=0
- hazard_o and req_ready_o are combinational from the current inputs and state. They are 0 while rst is high only as a consequence of inputs; the outputs themselves are not forced.
- Reset mid-operation: all state clears immediately. Units must discard in-flight results.
- Writeback latency: transfer in cycle T -> w_en_o high during T+1 -> the register file updates at the end of T+1.
- Scoreboard clear is visible in T+1, so a dependent instruction's hazard_o drops in T+1. Its operand read in T+1 gets the value via the register-file bypass.
- Issue accepted in cycle T -> pending[rd] high from T+1; hazard_o for a dependent instruction is high from T+1.
- Throughput: one writeback per cycle.

## Test plan
- Reset: assert rst mid-stream with pending[5]=1 and a transfer active -> pending_o=0, w_en_o=0, w_addr_o=0, w_data_o=0 during reset; after reset, unit 0 wins first.
- RAW stall: issue rd=7; next cycle present rs1=7 -> hazard_o=1. Unit 1 writes x7=0xDEADBEEF in cycle T -> T+1 shows w_en_o=1, w_addr_o=7, w_data_o=0xDEADBEEF, pending[7]=0, hazard_o=0.
- Round-robin: all three units hold valid continuously -> grants 0,1,2,0,1,2; each unit waits at most 2 cycles; the w_addr_o sequence matches.
- x0 write: a unit requests addr 0, data 0x1234 -> ready=1, next cycle w_en_o=0, w_addr_o=0, w_data_o=0; pending unchanged.
- WAW: rd=3 pending, issue with iss_wr_i=1, rd=3 -> hazard_o=1. The same instruction with iss_wr_i=0 and rs not pending -> hazard_o=0.
- Idle gaps: alternate valid/idle cycles on unit 2 only -> w_en_o pulses each transfer; w_addr_o and w_data_o return to 0 on idle cycles; rr_ptr stays at 0 after each grant to unit 2 (2+1 wraps to 0).
